traffic_fsm_ctrl: RTL and testbench
===================================

TRAFFIC_FSM_CTRL -- requirements
Module: traffic_fsm_ctrl

Interface
REQ-001 Parameter WALK_TIME, default 10, walk phase length in clk_1hz cycles; legal range 2..31.
REQ-002 clk_1hz  input  1  sole clock, rising edge, 1 Hz tick.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 time1  input  1  one-cycle green-expiry pulse from the phase timer.
REQ-005 time2  input  1  one-cycle yellow-expiry pulse from the phase timer.
REQ-006 side_sensor  input  1  level; side-road vehicle present.
REQ-007 ped_req  input  1  level or pulse; pedestrian button.
REQ-008 state  output  3  current phase, fed to the phase timer.
REQ-009 main_lights  output  3  {red,yellow,green}, one-hot.
REQ-010 side_lights  output  3  {red,yellow,green}, one-hot.
REQ-011 walk  output  1  pedestrian walk lamp.
REQ-012 ped_ack  output  1  one-cycle pulse when a pedestrian request is served.

Function
REQ-013 The block SHALL hold state in a register with encodings S0=0 main green, S1=1 main yellow, S2=2 side green, S3=3 side yellow, S4=4 all-red walk; codes 5-7 SHALL go to S0 on the next edge.
REQ-014 Light outputs SHALL be decoded from the state register only: S0 main G/side R; S1 main Y/side R; S2 main R/side G; S3 main R/side Y; S4 both R, walk=1; walk=0 elsewhere.
REQ-015 car_pend SHALL set on any edge with side_sensor=1 while state!=S2 and SHALL clear on the edge that enters S2.
REQ-016 ped_pend SHALL set on any edge with ped_req=1 while state!=S4 and SHALL clear on the edge that enters S4; clear wins if set and clear coincide.
REQ-017 S0 on time1: go to S1 if car_pend, side_sensor or ped_pend is 1; otherwise stay in S0 (main green extends by another timer period).
REQ-018 S1 on time2: go to S4 if ped_pend, else S2; on entering S4 from S1, ret_side=1.
REQ-019 S2 on time1: go to S3 unconditionally.
REQ-020 S3 on time2: go to S4 if ped_pend, else S0; on entering S4 from S3, ret_side=0.
REQ-021 S4 SHALL last exactly WALK_TIME cycles through a 5-bit walk counter that is 0 on entry and exits when it reaches WALK_TIME-1; the next state is S2 if ret_side=1, else S0.
REQ-022 time1 in S1/S3/S4 and time2 in S0/S2/S4 SHALL be ignored.
REQ-023 ped_ack SHALL be a registered pulse, high for exactly the first cycle of S4.
REQ-024 A state change SHALL take effect on the same rising edge that samples the qualifying pulse; no extra latency.

Reset
REQ-025 While rst_n=0: state=S0, main_lights=001, side_lights=100, walk=0, ped_ack=0, car_pend=0, ped_pend=0, ret_side=0, walk counter=0.
REQ-026 Reset assertion mid-phase, including mid-S4, SHALL abort immediately to the reset values, and pending requests SHALL be discarded.
REQ-027 The first qualifying pulse after rst_n rises SHALL be honoured normally.

Configuration
REQ-028 Macro PED_WALK_EN: when defined, REQ-016, REQ-018 (S4 branch), REQ-020 (S4 branch), REQ-021 and REQ-023 are active.
REQ-029 Without PED_WALK_EN: S4, ped_pend, ret_side and the walk counter are not built; ped_req is ignored; walk=0 and ped_ack=0 are constant; S1 goes to S2 and S3 goes to S0; ped_pend no longer counts as a reason to leave S0; code 4 is treated as illegal per REQ-013.

Verification
REQ-030 Release reset, then hold side_sensor=0 and ped_req=0 while time1 pulses 3 times -> state stays 0, main_lights=001 throughout.
REQ-031 Pulse side_sensor for 1 cycle in S0, then time1, then time2 -> state sequence 0,1,2; side_lights=001 in S2; car_pend cleared.
REQ-032 Run S2 then time1, time2 with ped_req pulsed during S3 (PED_WALK_EN) -> 3,4; walk=1 for exactly 10 cycles; ped_ack high on the first S4 cycle only; then state 0.
REQ-033 ped_req during S0, with side_sensor=1, then time1, time2 -> 0,1,4 for 10 cycles, then 2 (ret_side honoured).
REQ-034 Assert rst_n=0 on cycle 5 of S4 -> all outputs take reset values immediately; after release no ped_ack and state=0.
REQ-035 Without PED_WALK_EN, ped_req=1 constantly through a full cycle -> walk=0, ped_ack=0, state never reads 4.

Source files
------------

// File: rtl/traffic_fsm_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : traffic_fsm_ctrl                                           |
// | Description : Main/side road intersection phase controller with an       |
// |               optional all-red pedestrian walk phase (macro PED_WALK_EN). |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module traffic_fsm_ctrl #(
    parameter int WALK_TIME = 10
) (
    input  logic       clk_1hz,
    input  logic       rst_n,
    input  logic       time1,
    input  logic       time2,
    input  logic       side_sensor,
    input  logic       ped_req,
    output logic [2:0] state,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk,
    output logic       ped_ack
);

`ifdef PED_WALK_EN
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3
    } state_t;
`endif

    localparam logic [2:0] c_red = 3'b100;
    localparam logic [2:0] c_yel = 3'b010;
    localparam logic [2:0] c_grn = 3'b001;

    state_t r_state;
    state_t w_next;
    logic   r_car_pend;
    logic   w_enter_s2;
    logic   w_go_side;

    assign w_enter_s2 = (w_next == S2) && (r_state != S2);

`ifdef PED_WALK_EN
    localparam logic [4:0] c_walk_last = 5'(WALK_TIME - 1);

    logic       r_ped_pend;
    logic       r_ret_side;
    logic [4:0] r_walk_cnt;
    logic       r_ped_ack;
    logic       w_enter_s4;

    assign w_enter_s4 = (w_next == S4) && (r_state != S4);
    assign w_go_side  = r_car_pend | side_sensor | r_ped_pend;
`else
    // Walk phase absent: the pedestrian button and walk length have no function.
    localparam int c_unused_walk_time = WALK_TIME;
    logic w_unused_ped_req;

    assign w_unused_ped_req = ped_req;
    assign w_go_side        = r_car_pend | side_sensor;
`endif

    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S0;
        case (r_state)
            S0: w_next = (time1 && w_go_side) ? S1 : S0;
`ifdef PED_WALK_EN
            S1: w_next = time2 ? (r_ped_pend ? S4 : S2) : S1;
            S2: w_next = time1 ? S3 : S2;
            S3: w_next = time2 ? (r_ped_pend ? S4 : S0) : S3;
            S4: begin
                if (r_walk_cnt == c_walk_last) begin
                    w_next = r_ret_side ? S2 : S0;
                end else begin
                    w_next = S4;
                end
            end
`else
            S1: w_next = time2 ? S2 : S1;
            S2: w_next = time1 ? S3 : S2;
            S3: w_next = time2 ? S0 : S3;
`endif
            default: w_next = S0;
        endcase
    end

    // Clearing on entry to side green takes priority over a new sensor hit.
    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            r_car_pend <= 1'b0;
        end else if (w_enter_s2) begin
            r_car_pend <= 1'b0;
        end else if (side_sensor && (r_state != S2)) begin
            r_car_pend <= 1'b1;
        end
    end

`ifdef PED_WALK_EN
    always_ff @(posedge clk_1hz or negedge rst_n) begin
        if (!rst_n) begin
            r_ped_pend <= 1'b0;
            r_ret_side <= 1'b0;
            r_walk_cnt <= 5'd0;
            r_ped_ack  <= 1'b0;
        end else begin
            r_ped_ack <= w_enter_s4;
            if (w_enter_s4) begin
                r_ped_pend <= 1'b0;
            end else if (ped_req && (r_state != S4)) begin
                r_ped_pend <= 1'b1;
            end
            if (w_enter_s4) begin
                r_ret_side <= (r_state == S1);
            end
            if ((r_state == S4) && (w_next == S4)) begin
                r_walk_cnt <= r_walk_cnt + 5'd1;
            end else begin
                r_walk_cnt <= 5'd0;
            end
        end
    end

    assign walk    = (r_state == S4);
    assign ped_ack = r_ped_ack;
`else
    assign walk    = 1'b0;
    assign ped_ack = 1'b0;
`endif

    // Lamps depend on the state register alone; unknown codes show red both ways.
    always_comb begin
        main_lights = c_red;
        side_lights = c_red;
        case (r_state)
            S0: begin
                main_lights = c_grn;
                side_lights = c_red;
            end
            S1: begin
                main_lights = c_yel;
                side_lights = c_red;
            end
            S2: begin
                main_lights = c_red;
                side_lights = c_grn;
            end
            S3: begin
                main_lights = c_red;
                side_lights = c_yel;
            end
            default: begin
                main_lights = c_red;
                side_lights = c_red;
            end
        endcase
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_traffic_fsm_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_traffic_fsm_ctrl                                        |
// | Description : Directed self-checking bench for traffic_fsm_ctrl.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_traffic_fsm_ctrl;

    localparam int c_walk_time = 10;

    logic       clk_1hz;
    logic       rst_n;
    logic       time1;
    logic       time2;
    logic       side_sensor;
    logic       ped_req;
    logic [2:0] state;
    logic [2:0] main_lights;
    logic [2:0] side_lights;
    logic       walk;
    logic       ped_ack;

    int n_checks;
    int n_errors;

    traffic_fsm_ctrl #(
        .WALK_TIME(c_walk_time)
    ) dut (
        .clk_1hz    (clk_1hz),
        .rst_n      (rst_n),
        .time1      (time1),
        .time2      (time2),
        .side_sensor(side_sensor),
        .ped_req    (ped_req),
        .state      (state),
        .main_lights(main_lights),
        .side_lights(side_lights),
        .walk       (walk),
        .ped_ack    (ped_ack)
    );

    initial clk_1hz = 1'b0;
    always #5 clk_1hz = ~clk_1hz;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] st, input logic [2:0] ml,
                              input logic [2:0] sl, input logic wk, input logic ak);
        check({tag, ".state"}, {5'd0, state}, {5'd0, st});
        check({tag, ".main"},  {5'd0, main_lights}, {5'd0, ml});
        check({tag, ".side"},  {5'd0, side_lights}, {5'd0, sl});
        check({tag, ".walk"},  {7'd0, walk}, {7'd0, wk});
        check({tag, ".ack"},   {7'd0, ped_ack}, {7'd0, ak});
    endtask

    // Inputs change on the falling edge and hold for one full cycle.
    task automatic tick(input logic t1, input logic t2, input logic ss, input logic pr);
        @(negedge clk_1hz);
        time1       = t1;
        time2       = t2;
        side_sensor = ss;
        ped_req     = pr;
        @(posedge clk_1hz);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        time1       = 1'b0;
        time2       = 1'b0;
        side_sensor = 1'b0;
        ped_req     = 1'b0;
        #1;
        expect_out("reset", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        @(negedge clk_1hz);
        rst_n = 1'b1;

        // Main green holds with no demand.
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            expect_out("idle_t1", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        end

        // Latched car request drives a full side cycle.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("car_sense", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("car_wait", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("s0_to_s1", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("s1_ign_t1", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("s1_to_s2", 3'd2, 3'b100, 3'b001, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("s2_ign_t2", 3'd2, 3'b100, 3'b001, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("s2_to_s3", 3'd3, 3'b100, 3'b010, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("s3_ign_t1", 3'd3, 3'b100, 3'b010, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("s3_to_s0", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("car_cleared", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);

        // Live sensor on the time1 edge; sensor during side green is not latched.
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("live_sense", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("live_s2", 3'd2, 3'b100, 3'b001, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("s2_sense", 3'd2, 3'b100, 3'b001, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("live_s3", 3'd3, 3'b100, 3'b010, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("live_s0", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("no_s2_latch", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);

        // Reset in main yellow discards the pending car request.
        tick(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("pre_rst_s1", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_s1", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        @(negedge clk_1hz);
        rst_n = 1'b1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("post_rst_drop", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        expect_out("post_rst_go", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("post_rst_s2", 3'd2, 3'b100, 3'b001, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("back_s0", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);

`ifdef PED_WALK_EN
        // Pedestrian in S0 with a car waiting: walk, then return to side green.
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("ped_s0", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("ped_s1", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("walk_in_a", 3'd4, 3'b100, 3'b100, 1'b1, 1'b1);
        for (int i = 1; i < c_walk_time; i++) begin
            tick(1'b1, 1'b1, 1'b0, 1'b0);
            expect_out("walk_a", 3'd4, 3'b100, 3'b100, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("walk_ret_s2", 3'd2, 3'b100, 3'b001, 1'b0, 1'b0);

        // Pedestrian during side yellow: walk, then main green.
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("ped_s3", 3'd3, 3'b100, 3'b010, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        expect_out("walk_in_b", 3'd4, 3'b100, 3'b100, 1'b1, 1'b1);
        for (int i = 1; i < c_walk_time; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            expect_out("walk_b", 3'd4, 3'b100, 3'b100, 1'b1, 1'b0);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("walk_ret_s0", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);

        // Reset on the fifth walk cycle.
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("ped_only_s1", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end
        expect_out("walk_c5", 3'd4, 3'b100, 3'b100, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("rst_walk", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        @(negedge clk_1hz);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("rst_walk_idle", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        expect_out("rst_ped_drop", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
`else
        // Pedestrian button has no effect without the walk phase.
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("ped_ignored", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        expect_out("nped_s1", 3'd1, 3'b010, 3'b100, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        expect_out("nped_s2", 3'd2, 3'b100, 3'b001, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("nped_s3", 3'd3, 3'b100, 3'b010, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        expect_out("nped_s0", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        expect_out("nped_hold", 3'd0, 3'b001, 3'b100, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
